// File: rtl/pc_unit_if.sv
// Fetch-side control bundle for pc_unit: redirect requests in, program counter out.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             br_taken;
    logic [WIDTH-1:0] br_base;
    logic [WIDTH-1:0] br_offset;
    logic             jmp;
    logic [25:0]      jmp_index;
    logic             jr;
    logic [WIDTH-1:0] jr_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] incrPC;
    logic             redirect_pending;
    logic             misalign;

    modport master (
        output stall, br_taken, br_base, br_offset, jmp, jmp_index, jr, jr_target,
        input  pc, incrPC, redirect_pending, misalign
    );

    modport slave (
        input  stall, br_taken, br_base, br_offset, jmp, jmp_index, jr, jr_target,
        output pc, incrPC, redirect_pending, misalign
    );
endinterface

// File: rtl/pc_unit.sv
// IF-stage program counter with jr/jmp/branch select and a one-entry stall redirect buffer.
// Define PC_ALIGN_CHECK_EN to trap misaligned targets to EXC_VECTOR instead of masking them.
module pc_unit #(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       INCR         = 4,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
`ifdef PC_ALIGN_CHECK_EN
   ,parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0080)
`endif
) (
    input logic          clk,
    input logic          rst,
    pc_unit_if.slave     bus
);
    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StHeld = 1'b1;

    logic [0:0]       stateQ, stateD;
    logic [WIDTH-1:0] pcQ, pcD;
    logic [WIDTH-1:0] pendQ, pendD;
    logic [WIDTH-1:0] incrPC;
    logic [WIDTH-1:0] freshTgt;
    logic [WIDTH-1:0] loadTgt;
    logic             req;
    logic             misD;

    assign incrPC = pcQ + WIDTH'(INCR);
    assign req    = bus.jr | bus.jmp | bus.br_taken;

    always_comb begin
        if (bus.jr) begin
            freshTgt = bus.jr_target;
        end else if (bus.jmp) begin
            freshTgt = {bus.br_base[WIDTH-1:28], bus.jmp_index, 2'b00};
        end else begin
            freshTgt = bus.br_base + (bus.br_offset << 2);
        end
    end

    always_comb begin
        pcD     = pcQ;
        stateD  = stateQ;
        pendD   = pendQ;
        misD    = 1'b0;
        loadTgt = req ? freshTgt : pendQ;
        if (bus.stall) begin
            // Newest request wins the buffer; alignment is judged only when it is loaded.
            if (req) begin
                pendD  = freshTgt;
                stateD = StHeld;
            end
        end else begin
            stateD = StRun;
            if (req || (stateQ == StHeld)) begin
`ifdef PC_ALIGN_CHECK_EN
                if (loadTgt[1:0] != 2'b00) begin
                    pcD  = EXC_VECTOR;
                    misD = 1'b1;
                end else begin
                    pcD = loadTgt;
                end
`else
                pcD = loadTgt & ~WIDTH'(3);
`endif
            end else begin
                pcD = incrPC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcQ    <= RESET_VECTOR;
            pendQ  <= '0;
            stateQ <= StRun;
        end else begin
            pcQ    <= pcD;
            pendQ  <= pendD;
            stateQ <= stateD;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misQ;
    always_ff @(posedge clk) begin
        if (rst) misQ <= 1'b0;
        else     misQ <= misD;
    end
    assign bus.misalign = misQ;
`else
    logic unusedMis;
    assign unusedMis    = misD;
    assign bus.misalign = 1'b0;
`endif

    assign bus.pc               = pcQ;
    assign bus.incrPC           = incrPC;
    assign bus.redirect_pending = (stateQ == StHeld);
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential flow, redirect priority, stall buffering, wrap, reset.
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   numChecks = 0;
    int   numErrors = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(.WIDTH(32), .INCR(4), .RESET_VECTOR(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall     = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_base   = '0;
        bus.br_offset = '0;
        bus.jmp       = 1'b0;
        bus.jmp_index = '0;
        bus.jr        = 1'b0;
        bus.jr_target = '0;
    endtask

    task automatic jumpTo(input logic [31:0] tgt);
        bus.jr = 1'b1;
        bus.jr_target = tgt;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkEq("reset pc", bus.pc, 32'h0);
        checkEq("reset incr", bus.incrPC, 32'h4);
        checkEq("reset pend", 32'(bus.redirect_pending), 32'h0);
        checkEq("reset mis", 32'(bus.misalign), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkEq("seq pc", bus.pc, 32'(4 * i));
            checkEq("seq incr", bus.incrPC, 32'(4 * i + 4));
        end

        // Backward branch: 0x40 + (-2 << 2) = 0x38.
        jumpTo(32'h3C);
        checkEq("jr to 3c", bus.pc, 32'h3C);
        bus.br_taken = 1'b1; bus.br_base = 32'h40; bus.br_offset = 32'hFFFF_FFFE;
        tick(); idle();
        checkEq("branch back", bus.pc, 32'h38);

        jumpTo(32'h1C);
        bus.jmp = 1'b1; bus.jmp_index = 26'h10; bus.br_base = 32'h1000_0020;
        tick();
        checkEq("jmp target", bus.pc, 32'h1000_0040);
        bus.jr = 1'b1; bus.jr_target = 32'h200; bus.br_taken = 1'b1;
        tick(); idle();
        checkEq("jr priority", bus.pc, 32'h200);

        // Stall with two requests; the later one must be what lands.
        bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_base = 32'h100;
        tick();
        checkEq("stall1 pc", bus.pc, 32'h200);
        checkEq("stall1 pend", 32'(bus.redirect_pending), 32'h1);
        bus.br_taken = 1'b0; bus.jr = 1'b1; bus.jr_target = 32'h300;
        tick();
        checkEq("stall2 pc", bus.pc, 32'h200);
        bus.jr = 1'b0;
        tick();
        checkEq("stall3 pc", bus.pc, 32'h200);
        checkEq("stall3 pend", 32'(bus.redirect_pending), 32'h1);
        bus.stall = 1'b0;
        tick();
        checkEq("release pc", bus.pc, 32'h300);
        checkEq("release pend", 32'(bus.redirect_pending), 32'h0);
        tick();
        checkEq("after release", bus.pc, 32'h304);

        // Fresh request at release discards the buffered one.
        bus.stall = 1'b1; bus.jr = 1'b1; bus.jr_target = 32'h400;
        tick();
        bus.stall = 1'b0; bus.jr_target = 32'h500;
        tick(); idle();
        checkEq("fresh wins", bus.pc, 32'h500);
        checkEq("fresh pend", 32'(bus.redirect_pending), 32'h0);
        tick();
        checkEq("buffer dropped", bus.pc, 32'h504);

        jumpTo(32'hFFFF_FFFC);
        checkEq("wrap incr", bus.incrPC, 32'h0);
        tick();
        checkEq("wrap pc", bus.pc, 32'h0);

        bus.stall = 1'b1; bus.jr = 1'b1; bus.jr_target = 32'h600;
        tick();
        checkEq("pre-rst pend", 32'(bus.redirect_pending), 32'h1);
        rst = 1'b1;
        tick();
        checkEq("rst pc", bus.pc, 32'h0);
        checkEq("rst pend", 32'(bus.redirect_pending), 32'h0);
        rst = 1'b0; idle();
        tick();
        checkEq("post-rst pc", bus.pc, 32'h4);

        jumpTo(32'h202);
`ifdef PC_ALIGN_CHECK_EN
        checkEq("mis pc", bus.pc, 32'h80);
        checkEq("mis flag", 32'(bus.misalign), 32'h1);
        tick();
        checkEq("mis clear", 32'(bus.misalign), 32'h0);
        checkEq("mis next pc", bus.pc, 32'h84);
`else
        checkEq("mask pc", bus.pc, 32'h200);
        checkEq("mask flag", 32'(bus.misalign), 32'h0);
        tick();
        checkEq("mask next pc", bus.pc, 32'h204);
`endif

        // Misaligned buffered target: judged at release, not at capture.
        bus.stall = 1'b1; bus.jr = 1'b1; bus.jr_target = 32'h306;
        tick();
        checkEq("cap mis", 32'(bus.misalign), 32'h0);
        idle();
        tick();
`ifdef PC_ALIGN_CHECK_EN
        checkEq("buf mis pc", bus.pc, 32'h80);
        checkEq("buf mis flag", 32'(bus.misalign), 32'h1);
`else
        checkEq("buf mask pc", bus.pc, 32'h304);
        checkEq("buf mask flag", 32'(bus.misalign), 32'h0);
`endif
        checkEq("buf pend", 32'(bus.redirect_pending), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end
endmodule
